// File: rtl/fsub_pipe.sv
// Three-stage binary32 subtractor y = x1 - x2 with round-to-nearest-even and flush-to-zero.
// Stages: align -> add/sub + leading-zero count -> normalize, round and pack.
`timescale 1ns/1ps
module fsub_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        ready,
    output logic [31:0] y,
    output logic        valid
);

    // ---------------- S1: align ----------------
    logic        w_s2_eff;
    logic        w_sub;
    logic        w_x1_big;
    logic        w_sb;
    logic [7:0]  w_eb;
    logic [7:0]  w_es;
    logic [7:0]  w_diff;
    logic [23:0] w_mb;
    logic [23:0] w_ms;
    logic [4:0]  w_shamt;
    logic [54:0] w_ms_sh;
    logic [26:0] w_small;
    logic        w_spec;
    logic [31:0] w_spec_val;

    assign w_s2_eff = ~x2[31];
    assign w_sub    = x1[31] ^ w_s2_eff;
    // Comparing exponent:mantissa as one field orders magnitudes directly.
    assign w_x1_big = (x1[30:0] >= x2[30:0]);
    assign w_sb     = w_x1_big ? x1[31] : w_s2_eff;
    assign w_eb     = w_x1_big ? x1[30:23] : x2[30:23];
    assign w_es     = w_x1_big ? x2[30:23] : x1[30:23];
    assign w_mb     = {1'b1, (w_x1_big ? x1[22:0] : x2[22:0])};
    assign w_ms     = {1'b1, (w_x1_big ? x2[22:0] : x1[22:0])};
    assign w_diff   = w_eb - w_es;
    assign w_shamt  = (w_diff > 8'd31) ? 5'd31 : w_diff[4:0];
    assign w_ms_sh  = {w_ms, 31'b0} >> w_shamt;
    // Mantissa, guard, round, then sticky as the lowest bit.
    assign w_small  = {w_ms_sh[54:29], |w_ms_sh[28:0]};

    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = x1;
        if (x2[30:23] == 8'd0) begin
            w_spec_val = x1;
        end else if (x1[30:23] == 8'd0) begin
            w_spec_val = {~x2[31], x2[30:0]};
        end else if (w_sub && (x1[30:0] == x2[30:0])) begin
            w_spec_val = 32'h0000_0000;
        end else begin
            w_spec     = 1'b0;
            w_spec_val = 32'h0000_0000;
        end
    end

    logic        r1_vld;
    logic        r1_sign;
    logic        r1_sub;
    logic [7:0]  r1_exp;
    logic [23:0] r1_mb;
    logic [26:0] r1_small;
    logic        r1_spec;
    logic [31:0] r1_spec_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1_vld      <= 1'b0;
            r1_sign     <= 1'b0;
            r1_sub      <= 1'b0;
            r1_exp      <= 8'd0;
            r1_mb       <= 24'd0;
            r1_small    <= 27'd0;
            r1_spec     <= 1'b0;
            r1_spec_val <= 32'd0;
        end else begin
            r1_vld      <= ready;
            r1_sign     <= w_sb;
            r1_sub      <= w_sub;
            r1_exp      <= w_eb;
            r1_mb       <= w_mb;
            r1_small    <= w_small;
            r1_spec     <= w_spec;
            r1_spec_val <= w_spec_val;
        end
    end

    // ---------------- S2: add/sub, leading-zero count ----------------
    logic [27:0] w_sum_raw;
    logic [26:0] w_sum;
    logic [8:0]  w_exp2;
    logic [4:0]  w_lzc;

    assign w_sum_raw = r1_sub ? ({1'b0, r1_mb, 3'b000} - {1'b0, r1_small})
                              : ({1'b0, r1_mb, 3'b000} + {1'b0, r1_small});

    always_comb begin
        if (w_sum_raw[27]) begin
            w_sum  = {w_sum_raw[27:2], w_sum_raw[1] | w_sum_raw[0]};
            w_exp2 = {1'b0, r1_exp} + 9'd1;
        end else begin
            w_sum  = w_sum_raw[26:0];
            w_exp2 = {1'b0, r1_exp};
        end
    end

    always_comb begin
        w_lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_sum[i]) begin
                w_lzc = 5'(26 - i);
            end
        end
    end

    logic        r2_vld;
    logic        r2_sign;
    logic [8:0]  r2_exp;
    logic [26:0] r2_sum;
    logic [4:0]  r2_lzc;
    logic        r2_spec;
    logic [31:0] r2_spec_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r2_vld      <= 1'b0;
            r2_sign     <= 1'b0;
            r2_exp      <= 9'd0;
            r2_sum      <= 27'd0;
            r2_lzc      <= 5'd0;
            r2_spec     <= 1'b0;
            r2_spec_val <= 32'd0;
        end else begin
            r2_vld      <= r1_vld;
            r2_sign     <= r1_sign;
            r2_exp      <= w_exp2;
            r2_sum      <= w_sum;
            r2_lzc      <= w_lzc;
            r2_spec     <= r1_spec;
            r2_spec_val <= r1_spec_val;
        end
    end

    // ---------------- S3: normalize, round, pack ----------------
    logic        w_flush;
    logic [4:0]  w_sh;
    logic [26:0] w_norm;
    logic        w_rnd;
    logic [24:0] w_mant;
    logic [9:0]  w_exp3;
    logic [22:0] w_frac;
    logic [31:0] w_res;

    // A full normalize that would take the exponent below 1 means the result is subnormal.
    assign w_flush = ({4'b0, r2_lzc} >= r2_exp);
    assign w_sh    = w_flush ? 5'(r2_exp - 9'd1) : r2_lzc;
    assign w_norm  = r2_sum << w_sh;
    assign w_rnd   = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    assign w_mant  = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    assign w_exp3  = {1'b0, r2_exp} - {5'd0, w_sh} + {9'd0, w_mant[24]};
    assign w_frac  = w_mant[24] ? w_mant[23:1] : w_mant[22:0];

    always_comb begin
        if (r2_spec) begin
            w_res = r2_spec_val;
        end else if (w_flush) begin
            w_res = {r2_sign, 31'd0};
        end else if (w_exp3 >= 10'd255) begin
            w_res = {r2_sign, 8'hFF, 23'd0};
        end else begin
            w_res = {r2_sign, w_exp3[7:0], w_frac};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            y     <= 32'd0;
        end else begin
            valid <= r2_vld;
            if (r2_vld) begin
                y <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_fsub_pipe.sv
// Bench for fsub_pipe: directed vector table, random stream against an exact integer model,
// and an asynchronous reset applied while operations are in flight.
`timescale 1ns/1ps
module tb_fsub_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        ready;
    logic [31:0] y;
    logic        valid;

    always #5 clk = ~clk;

    fsub_pipe dut (
        .clk   (clk),
        .rstn  (rstn),
        .x1    (x1),
        .x2    (x2),
        .ready (ready),
        .y     (y),
        .valid (valid)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [95:0] sb_q[$];
    logic [2:0]  vpipe = 3'b000;
    logic [31:0] yhold = 32'd0;
    vec_t        tbl[12];

    // Exact reference: align on wide integers, RNE, flush below normal range.
    function automatic logic [31:0] model_sub(input logic [31:0] a, input logic [31:0] b);
        logic         sx, sy;
        int           ex, ey, d, p, sh, e;
        logic [23:0]  mx, my;
        logic [127:0] big, m, keep, rem, half;
        if (b[30:23] == 8'd0) return a;
        if (a[30:23] == 8'd0) return {~b[31], b[30:0]};
        if (a[30:0] >= b[30:0]) begin
            sx = a[31];  ex = 32'(a[30:23]); mx = {1'b1, a[22:0]};
            sy = ~b[31]; ey = 32'(b[30:23]); my = {1'b1, b[22:0]};
        end else begin
            sx = ~b[31]; ex = 32'(b[30:23]); mx = {1'b1, b[22:0]};
            sy = a[31];  ey = 32'(a[30:23]); my = {1'b1, a[22:0]};
        end
        d = ex - ey;
        if (d > 60) d = 60;
        big = 128'(mx) << d;
        m = (sx == sy) ? big + 128'(my) : big - 128'(my);
        if (m == 128'd0) return 32'h0000_0000;
        p = 0;
        for (int i = 0; i < 128; i++) if (m[i]) p = i;
        e = ex - d + p - 23;
        if (e <= 0) return {sx, 31'd0};
        if (p > 23) begin
            sh   = p - 23;
            keep = m >> sh;
            rem  = m & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            if ((rem > half) || ((rem == half) && keep[0])) keep = keep + 128'd1;
        end else begin
            keep = m << (23 - p);
        end
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {sx, 8'hFF, 23'd0};
        return {sx, 8'(e), keep[22:0]};
    endfunction

    task automatic check_outputs();
        logic [95:0] ent;
        total++;
        if (valid !== vpipe[2]) begin
            bad++;
            $display("FAIL valid_timing: valid=%b required=%b", valid, vpipe[2]);
        end
        if (valid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL stray_result: y=%h with no operation outstanding", y);
            end else begin
                ent = sb_q.pop_front();
                if (y !== ent[31:0]) begin
                    bad++;
                    $display("FAIL result: %h - %h gave y=%h required=%h", ent[95:64], ent[63:32], y, ent[31:0]);
                end else begin
                    $display("ok   %h - %h = %h", ent[95:64], ent[63:32], y);
                end
                yhold = ent[31:0];
            end
        end else begin
            total++;
            if (y !== yhold) begin
                bad++;
                $display("FAIL y_hold: y=%h required=%h while valid=0", y, yhold);
            end
        end
    endtask

    task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input logic r);
        @(negedge clk);
        check_outputs();
        x1    = a;
        x2    = b;
        ready = r;
        if (r) sb_q.push_back({a, b, e});
        vpipe = {vpipe[1:0], r};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          nops;

        rstn  = 1'b0;
        ready = 1'b0;
        x1    = 32'd0;
        x2    = 32'd0;

        tbl[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000};
        tbl[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000};
        tbl[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000};
        tbl[3]  = '{32'h3F800000, 32'h33800000, 32'h3F7FFFFF};
        tbl[4]  = '{32'h3F800000, 32'hB3800000, 32'h3F800000};
        tbl[5]  = '{32'h3F800000, 32'hB3800001, 32'h3F800001};
        tbl[6]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000};
        tbl[7]  = '{32'h00000000, 32'h40000000, 32'hC0000000};
        tbl[8]  = '{32'h40000000, 32'h00000000, 32'h40000000};
        tbl[9]  = '{32'h00800001, 32'h00800000, 32'h00000000};
        tbl[10] = '{32'h80800001, 32'h80800000, 32'h80000000};
        tbl[11] = '{32'h7F7FFFFF, 32'hF3000000, 32'h7F800000};

        #1;
        total++;
        if ((valid !== 1'b0) || (y !== 32'd0)) begin
            bad++;
            $display("FAIL reset_state: valid=%b y=%h required valid=0 y=00000000", valid, y);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors, back to back.
        for (int i = 0; i < 12; i++) cycle(tbl[i].a, tbl[i].b, tbl[i].e, 1'b1);
        idle(4);

        // Random normal operands with ready toggled.
        nops = 0;
        for (int k = 0; (k < 80) && (nops < 20); k++) begin
            if ($urandom_range(0, 2) != 0) begin
                ra = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
                case ($urandom_range(0, 3))
                    0:       rb = {1'($urandom), ra[30:23], 23'($urandom)};
                    1:       rb = {ra[31], ra[30:0] ^ 31'($urandom_range(0, 15))};
                    default: rb = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
                endcase
                cycle(ra, rb, model_sub(ra, rb), 1'b1);
                nops++;
            end else begin
                cycle(32'd0, 32'd0, 32'd0, 1'b0);
            end
        end
        idle(4);

        // Three ops in flight, then an asynchronous reset.
        cycle(tbl[0].a, tbl[0].b, tbl[0].e, 1'b1);
        cycle(tbl[3].a, tbl[3].b, tbl[3].e, 1'b1);
        cycle(tbl[5].a, tbl[5].b, tbl[5].e, 1'b1);
        @(posedge clk);
        #2;
        rstn  = 1'b0;
        ready = 1'b0;
        #1;
        total++;
        if ((valid !== 1'b0) || (y !== 32'd0)) begin
            bad++;
            $display("FAIL async_reset: valid=%b y=%h required valid=0 y=00000000", valid, y);
        end
        sb_q.delete();
        vpipe = 3'b000;
        yhold = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle(5);
        cycle(32'h40400000, 32'h3F800000, 32'h40000000, 1'b1);
        cycle(32'h3F800000, 32'hB3800001, 32'h3F800001, 1'b1);
        idle(4);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
